mux_onehot_rr_pipe: RTL and testbench

//  N-channel round-robin arbitrated mux with valid/ready handshake and one registered output stage.

---
 rtl/mux_onehot_rr_pipe.sv | 148 ++++++++++++++
 tb/tb_mux_onehot_rr_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_onehot_rr_pipe.sv
// mux_onehot_rr_pipe
// ------------------
// Round-robin arbitrated N:1 mux with valid/ready handshakes on both sides.
// It has one registered output stage. One requesting channel is picked per
// cycle. Its payload is forwarded, and its identity is reported as a one-hot
// grant and as a binary index. Throughput is one beat per cycle, and the
// output register may drain and refill in the same cycle.
//
// Optional feature (compile-time macro MUX_RR_LOCK_EN):
//   When the macro is defined, the in_last and out_last ports exist. A channel
//   that starts a multi-beat packet keeps the grant until its last beat is
//   accepted. When the macro is undefined, every beat is arbitrated
//   independently.
//
// Parameters:
//   NR_CH       number of input channels (>= 2, any value)
//   DATA_WIDTH  payload width per channel
//   IDX_WIDTH   derived width of out_idx (local, not overridable)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   per-channel request, bit i = channel i
//   in_ready   per-channel accept, at most one bit set, 0 while rst=1
//   in_data    channel i payload at [DATA_WIDTH*i +: DATA_WIDTH]
//   in_last    last beat of a packet (MUX_RR_LOCK_EN only)
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the held beat
//   out_data   registered payload
//   out_grant  one-hot source channel of out_data
//   out_idx    binary source channel of out_data
//   out_last   registered in_last of the source (MUX_RR_LOCK_EN only)
module mux_onehot_rr_pipe #(
    parameter int NR_CH      = 4,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_WIDTH = (NR_CH > 1) ? $clog2(NR_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_CH-1:0]            in_valid,
    output logic [NR_CH-1:0]            in_ready,
    input  logic [NR_CH*DATA_WIDTH-1:0] in_data,
`ifdef MUX_RR_LOCK_EN
    input  logic [NR_CH-1:0]            in_last,
    output logic                        out_last,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [NR_CH-1:0]            out_grant,
    output logic [IDX_WIDTH-1:0]        out_idx
);

    logic [IDX_WIDTH-1:0]  ptr_reg;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic [IDX_WIDTH-1:0]  ptr_next;
    logic                  any_req;
    logic                  slot_free;
    logic                  accept;
    logic [IDX_WIDTH:0]    cand;
    logic [DATA_WIDTH-1:0] ch_data [NR_CH];

`ifdef MUX_RR_LOCK_EN
    logic                  lock_reg;
    logic [IDX_WIDTH-1:0]  lock_ch_reg;
`endif

    // Unpack the flat payload bus so the selected channel can be indexed directly.
    for (genvar gi = 0; gi < NR_CH; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search. The loop runs from the farthest offset down to
    // offset 0, so the requester nearest to ptr is the last one written and
    // wins. The candidate index is one bit wider than IDX_WIDTH so that
    // ptr + k cannot overflow before it wraps modulo NR_CH.
    always_comb begin
        grant_idx = ptr_reg;
        any_req   = 1'b0;
        cand      = '0;
        for (int k = NR_CH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (IDX_WIDTH+1)'(k);
            if (cand >= (IDX_WIDTH+1)'(NR_CH)) begin
                cand = cand - (IDX_WIDTH+1)'(NR_CH);
            end
            if (in_valid[cand[IDX_WIDTH-1:0]]) begin
                grant_idx = cand[IDX_WIDTH-1:0];
                any_req   = 1'b1;
            end
        end
`ifdef MUX_RR_LOCK_EN
        // An open packet pins the grant, even while its channel is idle.
        if (lock_reg) begin
            grant_idx = lock_ch_reg;
            any_req   = in_valid[lock_ch_reg];
        end
`endif
    end

    assign slot_free = ~out_valid | out_ready;
    assign accept    = any_req & slot_free & ~rst;
    assign ptr_next  = (grant_idx == IDX_WIDTH'(NR_CH - 1)) ? '0
                                                            : grant_idx + IDX_WIDTH'(1);

    for (genvar gi = 0; gi < NR_CH; gi++) begin : g_ready
        assign in_ready[gi] = accept & (grant_idx == IDX_WIDTH'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            out_idx   <= '0;
            ptr_reg   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[grant_idx];
            out_grant <= in_ready;
            out_idx   <= grant_idx;
`ifdef MUX_RR_LOCK_EN
            // The pointer moves only when a packet closes. Mid-packet beats keep it.
            if (in_last[grant_idx]) begin
                ptr_reg <= ptr_next;
            end
`else
            ptr_reg   <= ptr_next;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_reg    <= 1'b0;
            lock_ch_reg <= '0;
            out_last    <= 1'b0;
        end else if (accept) begin
            lock_reg    <= ~in_last[grant_idx];
            lock_ch_reg <= grant_idx;
            out_last    <= in_last[grant_idx];
        end
    end
`endif

endmodule

// File: tb/tb_mux_onehot_rr_pipe.sv
// Directed testbench for mux_onehot_rr_pipe.
// The main instance is built with NR_CH=4 and DATA_WIDTH=8. A second instance
// with NR_CH=3 exercises pointer wrap-around when the channel count is not a
// power of two. The packet-lock steps are compiled only when MUX_RR_LOCK_EN
// is defined.
module tb_mux_onehot_rr_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_grant;
    logic [1:0]  out_idx;
    logic        out_last;

    logic [2:0]  v3;
    logic [2:0]  r3;
    logic [23:0] d3;
    logic [2:0]  l3;
    logic        ov3;
    logic        or3;
    logic [7:0]  od3;
    logic [2:0]  og3;
    logic [1:0]  oi3;
    logic        ol3;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mux_onehot_rr_pipe #(.NR_CH(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef MUX_RR_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_idx   (out_idx)
    );

    mux_onehot_rr_pipe #(.NR_CH(3), .DATA_WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v3),
        .in_ready  (r3),
        .in_data   (d3),
`ifdef MUX_RR_LOCK_EN
        .in_last   (l3),
        .out_last  (ol3),
`endif
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (od3),
        .out_grant (og3),
        .out_idx   (oi3)
    );

`ifndef MUX_RR_LOCK_EN
    assign out_last = 1'b0;
    assign ol3      = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ch;
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = 32'h13121110;
        in_last   = 4'hF;
        out_ready = 1'b1;
        v3        = 3'b000;
        d3        = 24'h222120;
        l3        = 3'b111;
        or3       = 1'b1;

        // Reset with every channel requesting.
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_grant", 32'(out_grant), 32'h0);
        check("rst_out_idx", 32'(out_idx), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_ready2", 32'(in_ready), 32'h0);

        // Round robin with all channels valid: 0,1,2,3,0.
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            ch = k % 4;
            check("rr_in_ready", 32'(in_ready), 32'(1) << ch);
            step();
            check("rr_out_idx", 32'(out_idx), 32'(ch));
            check("rr_out_data", 32'(out_data), 32'h10 + 32'(ch));
            check("rr_out_valid", 32'(out_valid), 32'h1);
            $display("beat rr ch=%0d data=%02h", out_idx, out_data);
        end

        // Drain with no requests. Payload fields hold their last values.
        in_valid = 4'h0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'h0);
        step();
        check("drain_out_valid", 32'(out_valid), 32'h0);
        check("drain_hold_data", 32'(out_data), 32'h10);

        // Stall: ch2 is accepted into the empty slot, then everything holds.
        in_valid         = 4'b0100;
        in_data[23:16]   = 8'hA5;
        out_ready        = 1'b0;
        #1;
        check("stall_fill_ready", 32'(in_ready), 32'h4);
        step();
        check("stall_out_data", 32'(out_data), 32'hA5);
        check("stall_out_grant", 32'(out_grant), 32'h4);
        check("stall_out_idx", 32'(out_idx), 32'h2);
        $display("beat stall ch=%0d data=%02h", out_idx, out_data);
        in_valid         = 4'b0010;
        in_data[15:8]    = 8'h3C;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'h0);
        step();
        check("stall_hold_data", 32'(out_data), 32'hA5);
        check("stall_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(in_ready), 32'h2);
        step();
        check("nobubble_data", 32'(out_data), 32'h3C);
        check("nobubble_valid", 32'(out_valid), 32'h1);
        check("nobubble_idx", 32'(out_idx), 32'h1);
        $display("beat unstall ch=%0d data=%02h", out_idx, out_data);
        in_valid = 4'h0;
        step();

        // Reset while a beat is held. The beat is dropped and the pointer restarts at 0.
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        step();
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        step();
        check("post_rst_valid", 32'(out_valid), 32'h0);
        check("post_rst_data", 32'(out_data), 32'h0);
        rst       = 1'b0;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        #1;
        check("restart_ready", 32'(in_ready), 32'h2);
        step();
        check("restart_idx", 32'(out_idx), 32'h1);
        check("restart_data", 32'(out_data), 32'h3C);
        $display("beat restart ch=%0d data=%02h", out_idx, out_data);
        in_valid = 4'h0;
        step();

`ifdef MUX_RR_LOCK_EN
        // ch1 sends a three-beat packet while ch0 keeps requesting. A gap mid-packet grants nothing.
        rst = 1'b1;
        step();
        rst           = 1'b0;
        in_valid      = 4'b0010;
        in_last       = 4'b0000;
        in_data[15:8] = 8'hB1;
        #1;
        check("lk_b1_ready", 32'(in_ready), 32'h2);
        step();
        check("lk_b1_idx", 32'(out_idx), 32'h1);
        in_valid      = 4'b0011;
        in_data[15:8] = 8'hB2;
        #1;
        check("lk_b2_ready", 32'(in_ready), 32'h2);
        step();
        check("lk_b2_data", 32'(out_data), 32'hB2);
        check("lk_b2_last", 32'(out_last), 32'h0);
        in_valid = 4'b0001;
        #1;
        check("lk_gap_ready", 32'(in_ready), 32'h0);
        step();
        check("lk_gap_valid", 32'(out_valid), 32'h0);
        in_valid      = 4'b0011;
        in_last       = 4'b0010;
        in_data[15:8] = 8'hB3;
        #1;
        check("lk_b3_ready", 32'(in_ready), 32'h2);
        step();
        check("lk_b3_idx", 32'(out_idx), 32'h1);
        check("lk_b3_last", 32'(out_last), 32'h1);
        in_valid = 4'b0001;
        #1;
        check("lk_ch0_ready", 32'(in_ready), 32'h1);
        step();
        check("lk_ch0_idx", 32'(out_idx), 32'h0);
        $display("beat lock ch=%0d data=%02h", out_idx, out_data);

        // Reset with the lock set and a beat held. Both are cleared.
        in_valid  = 4'b0010;
        in_last   = 4'b0000;
        out_ready = 1'b0;
        step();
        check("lkrst_pre_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        step();
        check("lkrst_valid", 32'(out_valid), 32'h0);
        check("lkrst_last", 32'(out_last), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        in_last   = 4'b0001;
        #1;
        check("lkrst_unlocked", 32'(in_ready), 32'h1);
        step();
        check("lkrst_idx", 32'(out_idx), 32'h0);
        in_valid = 4'h0;
        in_last  = 4'hF;
        step();
`endif

        // Three-channel instance: ch0 and ch2 alternate, and the pointer wraps from 2 to 0.
        v3 = 3'b101;
        #1;
        for (int k = 0; k < 5; k++) begin
            ch = (k % 2 == 1) ? 2 : 0;
            check("n3_in_ready", 32'(r3), 32'(1) << ch);
            step();
            check("n3_out_idx", 32'(oi3), 32'(ch));
            check("n3_out_grant", 32'(og3), 32'(1) << ch);
            check("n3_out_data", 32'(od3), 32'h20 + 32'(ch));
            $display("beat n3 ch=%0d data=%02h", oi3, od3);
        end
        v3 = 3'b000;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
